// File: rtl/seg7_scan_driver.sv
// Avalon-MM slave that scans up to 16 seven-segment digits over a shared segment bus,
// with per-digit blank, blink and decimal-point masks and register readback.
module seg7_scan_driver #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BLINK_HALF = 64,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              csi_clk,
    input  logic              csi_rst_n,
    input  logic              avs_cs,
    input  logic [4:0]        avs_add,
    input  logic              avs_rd,
    input  logic              avs_wr,
    input  logic [31:0]       avs_wrd,
    output logic [31:0]       avs_rdd,
    output logic [7:0]        coe_seg,
    output logic [DIGITS-1:0] coe_dig
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [3:0]    I_LAST = 4'(DIGITS - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_HALF - 1);

    localparam logic [4:0] A_DATA_LO = 5'd0;
    localparam logic [4:0] A_DATA_HI = 5'd1;
    localparam logic [4:0] A_BLANK   = 5'd2;
    localparam logic [4:0] A_BLINK   = 5'd3;
    localparam logic [4:0] A_DP      = 5'd4;
    localparam logic [4:0] A_CTRL    = 5'd5;
    localparam logic [4:0] A_STATUS  = 5'd6;

    logic [DIGITS*4-1:0] data_q;
    logic [DIGITS-1:0]   blank_q;
    logic [DIGITS-1:0]   blink_q;
    logic [DIGITS-1:0]   dp_q;
    logic                en_q;

    logic [PW-1:0] presc_q;
    logic [3:0]    idx_q;
    logic [FW-1:0] frame_q;
    logic          phase_q;

    logic          wr_en;
    logic          en_d;
    logic          run;
    logic [63:0]   data_w;
    logic [15:0]   blank_w;
    logic [15:0]   blink_w;
    logic [15:0]   dp_w;
    logic [31:0]   rd_c;
    logic [7:0]    seg_c;
    logic [DIGITS-1:0] dig_c;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign wr_en   = avs_cs & avs_wr;
    assign data_w  = 64'(data_q);
    assign blank_w = 16'(blank_q);
    assign blink_w = 16'(blink_q);
    assign dp_w    = 16'(dp_q);

    // Clearing EN stops the scan on the very edge it is written
    assign en_d = (wr_en && avs_add == A_CTRL) ? avs_wrd[0] : en_q;
    assign run  = en_q & en_d;

    // Register file; bits for digits beyond DIGITS are simply not stored
    always_ff @(posedge csi_clk or negedge csi_rst_n) begin
        if (!csi_rst_n) begin
            data_q  <= '0;
            blank_q <= '1;
            blink_q <= '0;
            dp_q    <= '0;
            en_q    <= 1'b1;
        end else if (wr_en) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (avs_add == ((i < 8) ? A_DATA_LO : A_DATA_HI))
                    data_q[4*i +: 4] <= avs_wrd[4*(i%8) +: 4];
            end
            case (avs_add)
                A_BLANK: blank_q <= avs_wrd[DIGITS-1:0];
                A_BLINK: blink_q <= avs_wrd[DIGITS-1:0];
                A_DP:    dp_q    <= avs_wrd[DIGITS-1:0];
                A_CTRL:  en_q    <= avs_wrd[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_c = '0;
        case (avs_add)
            A_DATA_LO: rd_c = data_w[31:0];
            A_DATA_HI: rd_c = data_w[63:32];
            A_BLANK:   rd_c = 32'(blank_q);
            A_BLINK:   rd_c = 32'(blink_q);
            A_DP:      rd_c = 32'(dp_q);
            A_CTRL:    rd_c = {31'd0, en_q};
            A_STATUS:  rd_c = {23'd0, phase_q, 4'd0, idx_q};
            default:   rd_c = '0;
        endcase
    end

    always_ff @(posedge csi_clk or negedge csi_rst_n) begin
        if (!csi_rst_n)
            avs_rdd <= '0;
        else if (avs_cs && avs_rd)
            avs_rdd <= rd_c;
    end

    // Prescaler -> digit index -> frame counter -> blink phase
    always_ff @(posedge csi_clk or negedge csi_rst_n) begin
        if (!csi_rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else if (!run) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else if (presc_q == P_LAST) begin
            presc_q <= '0;
            if (idx_q == I_LAST) begin
                idx_q <= '0;
                if (frame_q == F_LAST) begin
                    frame_q <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    frame_q <= frame_q + FW'(1);
                end
            end else begin
                idx_q <= idx_q + 4'd1;
            end
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    always_comb begin
        seg_c = {dp_w[idx_q], seg_decode(data_w[{idx_q, 2'b00} +: 4])};
        dig_c = DIGITS'(16'h1 << idx_q);
        if (blank_w[idx_q] || (blink_w[idx_q] && phase_q))
            seg_c = 8'h00;
        if (!en_q) begin
            seg_c = 8'h00;
            dig_c = '0;
        end
    end

    // Registered output stage keeps the segment bus and digit select changing together
    always_ff @(posedge csi_clk or negedge csi_rst_n) begin
        if (!csi_rst_n) begin
            coe_seg <= {8{ACTIVE_LOW}};
            coe_dig <= {DIGITS{ACTIVE_LOW}};
        end else begin
            coe_seg <= ACTIVE_LOW ? ~seg_c : seg_c;
            coe_dig <= ACTIVE_LOW ? ~dig_c : dig_c;
        end
    end

endmodule
